axis_byte_packer: RTL and testbench

AXI4-Stream byte compactor that sits directly upstream of the S2MM write engine. It removes null bytes (TKEEP=0 lanes, contiguous or not) from the incoming stream and re-packs the surviving bytes, in arrival order, into dense beats. Every output beat has all TKEEP lanes set except the final beat of a packet. The S2MM engine can then compute byte counts and addresses from TKEEP popcount without handling sparse lanes.

---
 rtl/axis_byte_packer.sv | 104 ++++++++++
 tb/tb_axis_byte_packer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_byte_packer.sv
// AXI4-Stream byte compactor: drops null (TKEEP=0) lanes and re-packs surviving
// bytes into dense beats. Only the final beat of a packet may be partially kept.
module axis_byte_packer #(
    parameter int DATA_BYTES = 4
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [8*DATA_BYTES-1:0] s_axis_tdata,
    input  logic [DATA_BYTES-1:0]   s_axis_tkeep,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [8*DATA_BYTES-1:0] m_axis_tdata,
    output logic [DATA_BYTES-1:0]   m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [31:0]             pkt_count
);
    localparam int NB = 2 * DATA_BYTES;
    localparam int CW = $clog2(NB + 1);
    localparam int DW = 8 * DATA_BYTES;
    localparam logic [CW-1:0] DB_C = CW'(DATA_BYTES);

    // Byte 0 of buf_q is the oldest byte; bytes at or above cnt_q are kept zero.
    logic [8*NB-1:0] buf_q, buf_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            last_pending_q, last_pending_d;
    logic            started_q, started_d;
    logic [31:0]     pkt_count_q, pkt_count_d;

    logic            s_hs, m_hs, out_valid, out_last;
    logic [CW-1:0]   pop_n, push_n, base;
    logic [DW-1:0]   packed_in;
    logic [8*NB-1:0] shifted;

    always_comb begin
        started_d     = 1'b1;
        s_axis_tready = started_q && !last_pending_q && (cnt_q <= DB_C);
        out_valid     = (cnt_q >= DB_C) || (last_pending_q && (cnt_q != '0));
        out_last      = last_pending_q && (cnt_q <= DB_C);
        s_hs          = s_axis_tvalid && s_axis_tready;
        m_hs          = out_valid && m_axis_tready;

        pop_n = '0;
        if (m_hs) begin
            pop_n = (cnt_q >= DB_C) ? DB_C : cnt_q;
        end
        base = cnt_q - pop_n;

        packed_in = '0;
        push_n    = '0;
        for (int k = 0; k < DATA_BYTES; k++) begin
            if (s_hs && s_axis_tkeep[k]) begin
                packed_in = packed_in | (DW'(s_axis_tdata[8*k +: 8]) << {push_n, 3'b000});
                push_n    = push_n + CW'(1);
            end
        end

        // Pop first, then append the compacted input after the surviving bytes.
        shifted = buf_q >> {pop_n, 3'b000};
        buf_d   = shifted | ({{DW{1'b0}}, packed_in} << {base, 3'b000});
        cnt_d   = base + push_n;

        last_pending_d = last_pending_q;
        if (s_hs && s_axis_tlast) begin
            last_pending_d = 1'b1;
        end else if ((m_hs && out_last) || (last_pending_q && (cnt_q == '0))) begin
            last_pending_d = 1'b0;
        end

        pkt_count_d = pkt_count_q + ((m_hs && out_last) ? 32'd1 : 32'd0);
    end

    always_comb begin
        m_axis_tdata = '0;
        m_axis_tkeep = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (CW'(i) < cnt_q) begin
                m_axis_tkeep[i]         = 1'b1;
                m_axis_tdata[8*i +: 8]  = buf_q[8*i +: 8];
            end
        end
        m_axis_tvalid = out_valid;
        m_axis_tlast  = out_last;
        pkt_count     = pkt_count_q;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            buf_q          <= '0;
            cnt_q          <= '0;
            last_pending_q <= 1'b0;
            started_q      <= 1'b0;
            pkt_count_q    <= '0;
        end else begin
            buf_q          <= buf_d;
            cnt_q          <= cnt_d;
            last_pending_q <= last_pending_d;
            started_q      <= started_d;
            pkt_count_q    <= pkt_count_d;
        end
    end
endmodule

// File: tb/tb_axis_byte_packer.sv
// Self-checking bench for axis_byte_packer: byte-queue reference model, directed
// literal cases and randomized packets with random output backpressure.
module tb_axis_byte_packer;
    localparam int DB = 4;
    localparam int DW = 8 * DB;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b1;
    logic [DW-1:0] s_axis_tdata;
    logic [DB-1:0] s_axis_tkeep;
    logic          s_axis_tlast;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [DB-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [31:0]   pkt_count;

    axis_byte_packer #(.DATA_BYTES(DB)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .pkt_count(pkt_count)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [DB-1:0] keep;
        logic          last;
        logic [31:0]   cyc;
    } beat_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 1;
    int model_pkts = 0;
    int exp_total;
    beat_t exp_q[$];
    beat_t got[$];
    logic [7:0] pend[$];
    beat_t mon_b;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: a packet's bytes, in arrival order, cut into DB-byte chunks.
    function automatic void emit(input logic last);
        beat_t b;
        b = '0;
        for (int i = 0; i < DB; i++) begin
            if (pend.size() > 0) begin
                b.data[8*i +: 8] = pend.pop_front();
                b.keep[i] = 1'b1;
            end
        end
        b.last = last;
        exp_q.push_back(b);
    endfunction

    always @(posedge aclk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge aclk);
            #1;
            case (rdy_mode)
                0: m_axis_tready = 1'b0;
                1: m_axis_tready = 1'b1;
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge aclk) begin
        if (!aresetn) begin
            exp_q.delete();
            pend.delete();
            model_pkts = 0;
        end else begin
            chk("pkt_count", pkt_count, 64'(model_pkts));
            if (m_axis_tvalid) begin
                if (exp_q.size() == 0) begin
                    chk("valid_with_no_data", m_axis_tvalid, 0);
                end else begin
                    chk("beat_data", m_axis_tdata, exp_q[0].data);
                    chk("beat_keep", m_axis_tkeep, exp_q[0].keep);
                    chk("beat_last", m_axis_tlast, exp_q[0].last);
                    if (m_axis_tready) begin
                        if (exp_q[0].last) model_pkts++;
                        mon_b.data = m_axis_tdata;
                        mon_b.keep = m_axis_tkeep;
                        mon_b.last = m_axis_tlast;
                        mon_b.cyc  = cyc;
                        got.push_back(mon_b);
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (s_axis_tvalid && s_axis_tready) begin
                for (int k = 0; k < DB; k++)
                    if (s_axis_tkeep[k]) pend.push_back(s_axis_tdata[8*k +: 8]);
                if (!s_axis_tlast) begin
                    while (pend.size() >= DB) emit(1'b0);
                end else begin
                    while (pend.size() > DB) emit(1'b0);
                    if (pend.size() > 0) emit(1'b1);
                end
            end
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic [DB-1:0] k, input logic l);
        bit acc;
        int n;
        s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tvalid = 1'b1;
        acc = 0; n = 0;
        while (!acc && n < 200) begin
            @(negedge aclk);
            acc = s_axis_tready;
            @(posedge aclk);
            #1;
            n++;
        end
        s_axis_tvalid = 1'b0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout actual=stalled required=accepted");
        end
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && n < maxc) begin
            @(posedge aclk);
            #1;
            n++;
        end
        chk("drain_done", 64'(exp_q.size() != 0 || m_axis_tvalid), 0);
        repeat (2) @(posedge aclk);
        #1;
    endtask

    task automatic expect_got(input int i, input logic [DW-1:0] d, input logic [DB-1:0] k,
                              input logic l);
        if (got.size() > i) begin
            chk("lit_data", got[i].data, d);
            chk("lit_keep", got[i].keep, k);
            chk("lit_last", got[i].last, l);
        end else begin
            chk("lit_missing_beat", 64'(got.size()), 64'(i + 1));
        end
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int nb;
        bit empty;
        logic [DB-1:0] k;
        aresetn = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b0;
        rdy_mode = 1;

        repeat (5) begin
            @(negedge aclk);
            chk("rst_s_tready", s_axis_tready, 0);
            chk("rst_m_tvalid", m_axis_tvalid, 0);
            chk("rst_m_tlast", m_axis_tlast, 0);
            chk("rst_m_tkeep", m_axis_tkeep, 0);
            chk("rst_m_tdata", m_axis_tdata, 0);
            chk("rst_pkt_count", pkt_count, 0);
        end
        @(posedge aclk); #1 aresetn = 1'b1;
        @(negedge aclk);
        chk("tready_before_edge", s_axis_tready, 0);
        @(posedge aclk); #1;
        chk("tready_after_release", s_axis_tready, 1);
        chk("tvalid_after_release", m_axis_tvalid, 0);

        // Sparse packet
        got.delete();
        send(32'h07060504, 4'h8, 1'b0);
        send(32'h0b0a0908, 4'hF, 1'b0);
        send(32'h0f0e0d0c, 4'h1, 1'b1);
        drain(50);
        expect_got(0, 32'h0a090807, 4'hF, 1'b0);
        expect_got(1, 32'h00000c0b, 4'h3, 1'b1);
        chk("sparse_beats", 64'(got.size()), 2);
        chk("sparse_pkts", pkt_count, 1);

        // Non-contiguous keep
        got.delete();
        send(32'h44332211, 4'h5, 1'b0);
        send(32'h88776655, 4'hA, 1'b1);
        drain(50);
        expect_got(0, 32'h88663311, 4'hF, 1'b1);
        chk("noncontig_beats", 64'(got.size()), 1);
        chk("noncontig_pkts", pkt_count, 2);

        // Dense input at full throughput
        got.delete();
        for (int i = 0; i < 4; i++) send(32'h13121110 + 32'(i) * 32'h04040404, 4'hF, 1'(i == 3));
        drain(50);
        for (int i = 0; i < 4; i++) expect_got(i, 32'h13121110 + 32'(i) * 32'h04040404, 4'hF, 1'(i == 3));
        for (int i = 1; i < 4; i++)
            if (got.size() > i) chk("throughput_gap", got[i].cyc - got[i-1].cyc, 1);
        chk("dense_pkts", pkt_count, 3);

        // Backpressure
        rdy_mode = 0;
        @(posedge aclk); #1;
        got.delete();
        send(32'h03020100, 4'hF, 1'b0);
        send(32'h07060504, 4'hF, 1'b0);
        fork
            send(32'h0b0a0908, 4'hF, 1'b1);
            begin
                repeat (4) begin
                    @(negedge aclk);
                    chk("bp_s_tready", s_axis_tready, 0);
                    chk("bp_m_tvalid", m_axis_tvalid, 1);
                    chk("bp_hold_data", m_axis_tdata, 32'h03020100);
                end
                rdy_mode = 1;
            end
        join
        drain(50);
        expect_got(0, 32'h03020100, 4'hF, 1'b0);
        expect_got(1, 32'h07060504, 4'hF, 1'b0);
        expect_got(2, 32'h0b0a0908, 4'hF, 1'b1);
        chk("bp_beats", 64'(got.size()), 3);
        chk("bp_pkts", pkt_count, 4);

        // Empty packet, then a normal one
        got.delete();
        send(32'h0, 4'h0, 1'b1);
        repeat (4) begin
            @(negedge aclk);
            chk("empty_no_valid", m_axis_tvalid, 0);
        end
        chk("empty_pkts", pkt_count, 4);
        @(posedge aclk); #1;
        send(32'hDDCCBBAA, 4'hF, 1'b1);
        drain(50);
        expect_got(0, 32'hDDCCBBAA, 4'hF, 1'b1);
        chk("after_empty_beats", 64'(got.size()), 1);
        chk("after_empty_pkts", pkt_count, 5);

        // Reset mid-packet
        got.delete();
        send(32'h11223344, 4'h3, 1'b0);
        aresetn = 1'b0;
        #1;
        chk("midrst_m_tvalid", m_axis_tvalid, 0);
        chk("midrst_pkt_count", pkt_count, 0);
        chk("midrst_m_tkeep", m_axis_tkeep, 0);
        repeat (2) @(negedge aclk);
        @(posedge aclk); #1 aresetn = 1'b1;
        @(posedge aclk); #1;
        send(32'h55667788, 4'hF, 1'b1);
        drain(50);
        expect_got(0, 32'h55667788, 4'hF, 1'b1);
        chk("midrst_beats", 64'(got.size()), 1);
        chk("midrst_pkts", pkt_count, 1);

        // Randomized packets with random backpressure
        exp_total = 1;
        rdy_mode = 2;
        for (int p = 0; p < 40; p++) begin
            nb = $urandom_range(1, 6);
            empty = ($urandom_range(0, 7) == 0);
            if (!empty) exp_total++;
            for (int b = 0; b < nb; b++) begin
                k = empty ? 4'h0 : DB'($urandom_range(0, 15));
                if (b == nb - 1 && !empty && k == 4'h0) k = DB'($urandom_range(1, 15));
                repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
                send($urandom, k, 1'(b == nb - 1));
            end
        end
        rdy_mode = 1;
        drain(500);
        chk("random_pkts", pkt_count, 64'(exp_total));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
